key_event_decoder: RTL and testbench

Parametrised UART-byte-to-key decoder with NUM_KEYS programmable channels. Each channel has an ASCII code, optional case folding, a hold-pulse output, a one-cycle strobe and a per-channel cooldown. Accepted keypresses are queued in a small event FIFO with a valid/ready handshake, so the game FSM can consume keys without missing short pulses. The block sits between the UART receiver (data/rx_valid) and the game control logic.

---
 rtl/key_event_decoder.sv | 182 ++++++++++++++++++
 tb/tb_key_event_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns rising edges of a UART byte-valid strobe into per-channel key
//   events. Each channel matches one ASCII code (optionally case-folded).
//   A hit on a channel produces:
//     - a one-cycle strobe,
//     - a stretched hold pulse,
//     - a cooldown lockout against re-triggering,
//     - an {index, byte} entry in a small first-word-fall-through event FIFO.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   data       in   [7:0] received UART byte
//   rx_valid   in   byte-valid level; only its rising edge is used
//   key_hold   out  [NUM_KEYS-1:0] per-channel stretched pulse
//   key_strobe out  [NUM_KEYS-1:0] per-channel single-cycle hit pulse
//   evt_valid  out  event FIFO non-empty
//   evt_ready  in   consumer pop request
//   evt_index  out  [IDX_W-1:0] channel index of the head entry
//   evt_code   out  [7:0] folded byte of the head entry
//   drop_cnt   out  [7:0] saturating count of hits lost to a full FIFO
module key_event_decoder #(
    parameter int                    NUM_KEYS        = 6,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES       = 48'h0D_20_64_61_73_77,
    parameter int                    HOLD_CYCLES     = 1000,
    parameter int                    COOLDOWN_CYCLES = 500000,
    parameter int                    CASE_FOLD       = 1,
    parameter int                    FIFO_DEPTH      = 4,
    localparam int                   IDX_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_hold,
    output logic [NUM_KEYS-1:0] key_strobe,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_index,
    output logic [7:0]          evt_code,
    output logic [7:0]          drop_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int COOL_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = IDX_W + 8;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
        if ((CASE_FOLD != 0) && (b >= 8'h41) && (b <= 8'h5A)) begin
            return b | 8'h20;
        end
        return b;
    endfunction

    logic                rx_valid_q;
    logic [NUM_KEYS-1:0] strobe_q;
    logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
    logic [COOL_W-1:0]   cool_q [NUM_KEYS];
    logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          drop_q, drop_d;

    logic                accept;
    logic [7:0]          fb;
    logic                match_found;
    logic [IDX_W-1:0]    match_idx;
    logic                hit;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic [ENT_W-1:0]    head;

    assign accept = rx_valid & ~rx_valid_q;
    assign fb     = fold_byte(data);

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == fb) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    assign hit = accept & match_found & (cool_q[match_idx] == '0);

    assign evt_valid = (count_q != '0);
    assign full      = (count_q == CNT_FULL);
    assign pop       = evt_valid & evt_ready;
    // A full FIFO still takes the push when a pop frees the head slot on the same edge.
    assign push_ok   = hit & (~full | pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (hit && !push_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            strobe_q   <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                hold_q[i] <= '0;
                cool_q[i] <= '0;
            end
        end else begin
            rx_valid_q <= rx_valid;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (hit && (match_idx == IDX_W'(i))) begin
                    strobe_q[i] <= 1'b1;
                    // Reloading while still high keeps the hold pulse continuous.
                    hold_q[i]   <= HOLD_LOAD;
                    cool_q[i]   <= COOL_LOAD;
                end else begin
                    strobe_q[i] <= 1'b0;
                    if (hold_q[i] != '0) begin
                        hold_q[i] <= hold_q[i] - HOLD_W'(1);
                    end
                    if (cool_q[i] != '0) begin
                        cool_q[i] <= cool_q[i] - COOL_W'(1);
                    end
                end
            end
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_q] <= {match_idx, fb};
        end
    end

    assign head = fifo_q[rd_q];

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_hold[i] = (hold_q[i] != '0);
        end
    end

    assign key_strobe = strobe_q;
    assign evt_index  = evt_valid ? head[8 +: IDX_W] : '0;
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_key_event_decoder.sv
module tb_key_event_decoder;

    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic       rxv;
        logic       rdy;
        logic [5:0] stb;
        logic [5:0] hold;
        logic       ev;
        logic [2:0] idx;
        logic [7:0] code;
        logic [7:0] drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, rx_valid, evt_ready;
    logic [7:0] data;
    logic [5:0] key_hold, key_strobe;
    logic       evt_valid;
    logic [2:0] evt_index;
    logic [7:0] evt_code, drop_cnt;

    logic       nf_reset, nf_rx_valid, nf_evt_ready;
    logic [7:0] nf_data;
    logic [5:0] nf_key_hold, nf_key_strobe;
    logic       nf_evt_valid;
    logic [2:0] nf_evt_index;
    logic [7:0] nf_evt_code, nf_drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    key_event_decoder #(
        .NUM_KEYS(6), .KEY_CODES(48'h0D_20_64_61_73_77), .HOLD_CYCLES(4),
        .COOLDOWN_CYCLES(10), .CASE_FOLD(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .data(data), .rx_valid(rx_valid),
        .key_hold(key_hold), .key_strobe(key_strobe), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_index(evt_index), .evt_code(evt_code),
        .drop_cnt(drop_cnt)
    );

    key_event_decoder #(
        .NUM_KEYS(6), .KEY_CODES(48'h0D_20_64_61_73_77), .HOLD_CYCLES(4),
        .COOLDOWN_CYCLES(10), .CASE_FOLD(0), .FIFO_DEPTH(4)
    ) dut_nf (
        .clk(clk), .reset(nf_reset), .data(nf_data), .rx_valid(nf_rx_valid),
        .key_hold(nf_key_hold), .key_strobe(nf_key_strobe), .evt_valid(nf_evt_valid),
        .evt_ready(nf_evt_ready), .evt_index(nf_evt_index), .evt_code(nf_evt_code),
        .drop_cnt(nf_drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] d, input logic v, input logic y,
                       input logic [5:0] s, input logic [5:0] h, input logic e,
                       input logic [2:0] ix, input logic [7:0] c, input logic [7:0] dr);
        vec_t t;
        t.rst = r; t.data = d; t.rxv = v; t.rdy = y;
        t.stb = s; t.hold = h; t.ev = e; t.idx = ix; t.code = c; t.drop = dr;
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits;
        int strobes;

        reset = 1'b1; data = 8'h00; rx_valid = 1'b0; evt_ready = 1'b0;
        nf_reset = 1'b1; nf_data = 8'h00; nf_rx_valid = 1'b0; nf_evt_ready = 1'b0;

        // rst data  rxv rdy | stb   hold  ev idx code  drop
        add(1, 8'h00, 0, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);   // reset state
        // single 'w' hit, cooldown lockout, re-hit after cooldown
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h77, 1, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h00, 1, 0, 8'h77, 8'd0);
        add(0, 8'h77, 1, 0, 6'h00, 6'h00, 1, 0, 8'h77, 8'd0);   // T+5: locked out
        for (int i = 0; i < 5; i++)
            add(0, 8'h00, 0, 0, 6'h00, 6'h00, 1, 0, 8'h77, 8'd0);
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);   // T+11: hit
        add(0, 8'h00, 0, 1, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);   // pop 1 of 2
        add(0, 8'h00, 0, 1, 6'h00, 6'h01, 0, 0, 8'h00, 8'd0);   // pop 2 of 2
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 0, 0, 8'h00, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        // case fold 'W' and unmatched 'x'
        add(1, 8'h00, 0, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        add(0, 8'h57, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h78, 1, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 1, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        // full FIFO with hit and pop on the same edge
        add(1, 8'h00, 0, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h73, 1, 0, 6'h02, 6'h03, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h03, 1, 0, 8'h77, 8'd0);
        add(0, 8'h61, 1, 0, 6'h04, 6'h06, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h06, 1, 0, 8'h77, 8'd0);
        add(0, 8'h64, 1, 0, 6'h08, 6'h0C, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h0C, 1, 0, 8'h77, 8'd0);
        add(0, 8'h20, 1, 1, 6'h10, 6'h18, 1, 1, 8'h73, 8'd0);
        add(0, 8'h00, 0, 1, 6'h00, 6'h18, 1, 2, 8'h61, 8'd0);
        add(0, 8'h00, 0, 1, 6'h00, 6'h10, 1, 3, 8'h64, 8'd0);
        add(0, 8'h00, 0, 1, 6'h00, 6'h10, 1, 4, 8'h20, 8'd0);
        add(0, 8'h00, 0, 1, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        // six hits into a 4-deep FIFO, then drain
        add(1, 8'h00, 0, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd0);
        add(0, 8'h73, 1, 0, 6'h02, 6'h03, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h03, 1, 0, 8'h77, 8'd0);
        add(0, 8'h61, 1, 0, 6'h04, 6'h06, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h06, 1, 0, 8'h77, 8'd0);
        add(0, 8'h64, 1, 0, 6'h08, 6'h0C, 1, 0, 8'h77, 8'd0);
        add(0, 8'h00, 0, 0, 6'h00, 6'h0C, 1, 0, 8'h77, 8'd0);
        add(0, 8'h20, 1, 0, 6'h10, 6'h18, 1, 0, 8'h77, 8'd1);
        add(0, 8'h00, 0, 0, 6'h00, 6'h18, 1, 0, 8'h77, 8'd1);
        add(0, 8'h0D, 1, 0, 6'h20, 6'h30, 1, 0, 8'h77, 8'd2);
        add(0, 8'h00, 0, 0, 6'h00, 6'h30, 1, 0, 8'h77, 8'd2);
        add(0, 8'h00, 0, 1, 6'h00, 6'h20, 1, 1, 8'h73, 8'd2);
        add(0, 8'h00, 0, 1, 6'h00, 6'h20, 1, 2, 8'h61, 8'd2);
        add(0, 8'h00, 0, 1, 6'h00, 6'h00, 1, 3, 8'h64, 8'd2);
        add(0, 8'h00, 0, 1, 6'h00, 6'h00, 0, 0, 8'h00, 8'd2);
        // reset in the middle of a hold, then an immediate re-hit
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd2);
        add(0, 8'h00, 0, 0, 6'h00, 6'h01, 1, 0, 8'h77, 8'd2);
        add(1, 8'h77, 1, 0, 6'h00, 6'h00, 0, 0, 8'h00, 8'd0);
        add(0, 8'h77, 1, 0, 6'h01, 6'h01, 1, 0, 8'h77, 8'd0);

        foreach (vecs[k]) begin
            reset     = vecs[k].rst;
            data      = vecs[k].data;
            rx_valid  = vecs[k].rxv;
            evt_ready = vecs[k].rdy;
            step();
            chk($sformatf("vec%0d {stb,hold,ev,idx,code,drop}", k),
                {key_strobe, key_hold, evt_valid, evt_index, evt_code, drop_cnt},
                {vecs[k].stb, vecs[k].hold, vecs[k].ev, vecs[k].idx, vecs[k].code, vecs[k].drop});
        end

        // rx_valid held high for 50 cycles gives a single hit
        reset = 1'b1; rx_valid = 1'b0; evt_ready = 1'b0; data = 8'h00;
        step();
        reset = 1'b0; data = 8'h0D; rx_valid = 1'b1;
        hits = 0; strobes = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (key_strobe[5]) hits++;
            strobes += $countones(key_strobe);
        end
        chk("held_rx_hits_ch5", hits, 1);
        chk("held_rx_strobes_all", strobes, 1);
        chk("held_rx_head {ev,idx,code}", {evt_valid, evt_index, evt_code}, {1'b1, 3'd5, 8'h0D});
        rx_valid = 1'b0; evt_ready = 1'b1;
        step();
        chk("held_rx_single_entry ev", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // no case folding: 'W' does not match, 'x' never matches, 'w' does
        nf_reset = 1'b1;
        step();
        chk("nf_reset {stb,ev,drop}", {nf_key_strobe, nf_evt_valid, nf_drop_cnt}, 0);
        nf_reset = 1'b0; nf_data = 8'h57; nf_rx_valid = 1'b1;
        step();
        chk("nf_upper_W {stb,hold,ev}", {nf_key_strobe, nf_key_hold, nf_evt_valid}, 0);
        nf_rx_valid = 1'b0;
        step();
        nf_data = 8'h78; nf_rx_valid = 1'b1;
        step();
        chk("nf_x {stb,hold,ev}", {nf_key_strobe, nf_key_hold, nf_evt_valid}, 0);
        nf_rx_valid = 1'b0;
        step();
        nf_data = 8'h77; nf_rx_valid = 1'b1;
        step();
        chk("nf_w {stb,ev,idx,code}", {nf_key_strobe, nf_evt_valid, nf_evt_index, nf_evt_code},
            {6'h01, 1'b1, 3'd0, 8'h77});
        nf_rx_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
